// File: rtl/flac_pkg.sv
// Shared FLAC encoder types and constants: FSM state encodings, field widths
// and the zigzag mapping used by the Rice coder.
package flac_pkg;

  localparam int RICE_PARAM_W = 4;
  localparam int PART_ORDER_W = 4;
  localparam logic [1:0] CODING_METHOD_RICE = 2'b00;
  localparam logic [RICE_PARAM_W-1:0] RICE_ESCAPE = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_PARAM_WAIT,
    S_PARAM,
    S_RES_WAIT,
    S_UNARY,
    S_STOP,
    S_REM,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic logic [15:0] zigzag(input logic [15:0] r);
    return {r[14:0], 1'b0} ^ {16{r[15]}};
  endfunction

endpackage

// File: rtl/rice_encoder.sv
// Serializes one residual as unary(q), stop bit, then k remainder bits MSB-first.
// Phases reuse the shared state encodings; S_IDLE means nothing in flight.
module rice_encoder
  import flac_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             residual,
  input  logic [RICE_PARAM_W-1:0] k,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    last
);

  state_t                  phase;
  logic [15:0]             q_cnt;
  logic [15:0]             rem;
  logic [RICE_PARAM_W-1:0] k_r;
  logic [RICE_PARAM_W-1:0] rem_cnt;
  logic [15:0]             u;
  logic [15:0]             q_start;
  logic [15:0]             rem_start;

  assign u         = zigzag(residual);
  assign q_start   = u >> k;
  assign rem_start = u & ((16'd1 << k) - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= S_IDLE;
      q_cnt   <= '0;
      rem     <= '0;
      k_r     <= '0;
      rem_cnt <= '0;
    end else if (start) begin
      k_r   <= k;
      rem   <= rem_start;
      q_cnt <= q_start;
      phase <= (q_start == 16'd0) ? S_STOP : S_UNARY;
    end else begin
      case (phase)
        S_UNARY: begin
          q_cnt <= q_cnt - 16'd1;
          if (q_cnt == 16'd1) phase <= S_STOP;
        end
        S_STOP: begin
          rem_cnt <= k_r;
          phase   <= (k_r == '0) ? S_IDLE : S_REM;
        end
        S_REM: begin
          rem_cnt <= rem_cnt - 4'd1;
          if (rem_cnt == 4'd1) phase <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign bit_valid = (phase == S_UNARY) || (phase == S_STOP) || (phase == S_REM);
  assign bit_out   = (phase == S_STOP) || ((phase == S_REM) && rem[rem_cnt - 4'd1]);
  assign last      = ((phase == S_STOP) && (k_r == '0)) ||
                     ((phase == S_REM) && (rem_cnt == 4'd1));

endmodule

// File: rtl/residual_encoder.sv
// Partitioned-Rice residual encoder: partition FSM plus MSB-first 16-bit word packer.
// state        | meaning
// S_IDLE       | waiting for iEnable
// S_HDR        | emitting coding method + partition order (6 bits)
// S_PARAM_WAIT | oParamReq high, waiting for the partition's k
// S_PARAM      | emitting k (4 bits)
// S_RES_WAIT   | oReady high, waiting for a residual
// S_UNARY      | residual in flight; rice_encoder steps unary/stop/remainder
// S_FLUSH      | writing any partial word, latching end pointer
// S_DONE       | oDone pulse issued on exit
module residual_encoder
  import flac_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                    iClock,
  input  logic                    iReset_n,
  input  logic                    iEnable,
  input  logic [DATA_W-1:0]       iNSamples,
  input  logic [3:0]              iPredOrder,
  input  logic [PART_ORDER_W-1:0] iPartOrder,
  input  logic [DATA_W-1:0]       iStartAddr,
  input  logic [4:0]              iStartBit,
  input  logic [DATA_W-1:0]       iStartWord,
  output logic                    oParamReq,
  input  logic                    iParamValid,
  input  logic [RICE_PARAM_W-1:0] iRiceParam,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [DATA_W-1:0]       iResidual,
  output logic                    oWriteEn,
  output logic [DATA_W-1:0]       oWriteAddr,
  output logic [DATA_W-1:0]       oWriteData,
  output logic                    oDone,
  output logic [DATA_W-1:0]       oEndAddr,
  output logic [4:0]              oEndBit
);

  state_t                  state;
  logic [3:0]              bit_ptr;
  logic [2:0]              bit_cnt;
  logic [DATA_W-1:0]       word_buf;
  logic [DATA_W-1:0]       word_next;
  logic [DATA_W-1:0]       addr;
  logic [DATA_W-1:0]       res_left;
  logic [DATA_W-1:0]       part_left;
  logic [PART_ORDER_W-1:0] part_order;
  logic [3:0]              pred_order;
  logic [RICE_PARAM_W-1:0] k;
  logic                    first_part;
  logic                    accept;
  logic                    emit;
  logic                    bit_val;
  logic                    enc_bit;
  logic                    enc_valid;
  logic                    enc_last;
  logic [5:0]              hdr;
  logic [DATA_W-1:0]       part_size;
  logic [DATA_W:0]         size0;

  assign accept    = oReady && iValid;
  assign hdr       = {CODING_METHOD_RICE, part_order};
  assign part_size = iNSamples >> part_order;
  // Partition 0 loses the warm-up samples; a non-positive result means empty.
  assign size0     = {1'b0, part_size} - {{(DATA_W-3){1'b0}}, pred_order};

  rice_encoder u_rice (
    .clk       (iClock),
    .rst_n     (iReset_n),
    .start     (accept),
    .residual  (iResidual),
    .k         (k),
    .bit_out   (enc_bit),
    .bit_valid (enc_valid),
    .last      (enc_last)
  );

  always_comb begin
    emit    = 1'b0;
    bit_val = 1'b0;
    case (state)
      S_HDR:   begin emit = 1'b1;      bit_val = hdr[bit_cnt];    end
      S_PARAM: begin emit = 1'b1;      bit_val = k[bit_cnt[1:0]]; end
      S_UNARY: begin emit = enc_valid; bit_val = enc_bit;         end
      default: ;
    endcase
    word_next          = word_buf;
    word_next[bit_ptr] = bit_val;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= S_IDLE;
      bit_ptr    <= '0;
      bit_cnt    <= '0;
      word_buf   <= '0;
      addr       <= '0;
      res_left   <= '0;
      part_left  <= '0;
      part_order <= '0;
      pred_order <= '0;
      k          <= '0;
      first_part <= 1'b0;
      oParamReq  <= 1'b0;
      oReady     <= 1'b0;
      oWriteEn   <= 1'b0;
      oWriteAddr <= '0;
      oWriteData <= '0;
      oDone      <= 1'b0;
      oEndAddr   <= '0;
      oEndBit    <= '0;
    end else begin
      oWriteEn <= 1'b0;
      oDone    <= 1'b0;

      if (emit) begin
        if (bit_ptr == 4'd0) begin
          oWriteEn   <= 1'b1;
          oWriteAddr <= addr;
          oWriteData <= word_next;
          addr       <= addr + 1'b1;
          word_buf   <= '0;
          bit_ptr    <= 4'd15;
        end else begin
          word_buf <= word_next;
          bit_ptr  <= bit_ptr - 4'd1;
        end
      end

      case (state)
        S_IDLE: if (iEnable) begin
          state      <= S_HDR;
          bit_cnt    <= 3'd5;
          bit_ptr    <= iStartBit[3:0];
          word_buf   <= iStartWord & ~(16'hFFFF >> (5'd15 - iStartBit));
          addr       <= iStartAddr;
          part_order <= iPartOrder;
          pred_order <= iPredOrder;
          part_left  <= (16'd1 << iPartOrder) - 16'd1;
          first_part <= 1'b1;
        end
        S_HDR: begin
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            state     <= S_PARAM_WAIT;
            oParamReq <= 1'b1;
          end
        end
        S_PARAM_WAIT: if (iParamValid) begin
          k          <= (iRiceParam == RICE_ESCAPE) ? RICE_ESCAPE - 4'd1 : iRiceParam;
          oParamReq  <= 1'b0;
          bit_cnt    <= 3'd3;
          first_part <= 1'b0;
          state      <= S_PARAM;
          if (first_part) res_left <= size0[DATA_W] ? '0 : size0[DATA_W-1:0];
          else            res_left <= part_size;
        end
        S_RES_WAIT: if (iValid) begin
          oReady   <= 1'b0;
          res_left <= res_left - 1'b1;
          state    <= S_UNARY;
        end
        S_PARAM, S_UNARY: begin
          if (state == S_PARAM) bit_cnt <= bit_cnt - 3'd1;
          if ((state == S_PARAM && bit_cnt == 3'd0) || (state == S_UNARY && enc_last)) begin
            if (res_left != '0) begin
              state  <= S_RES_WAIT;
              oReady <= 1'b1;
            end else if (part_left != '0) begin
              part_left <= part_left - 1'b1;
              state     <= S_PARAM_WAIT;
              oParamReq <= 1'b1;
            end else begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          oEndAddr <= addr;
          if (bit_ptr != 4'd15) begin
            oWriteEn   <= 1'b1;
            oWriteAddr <= addr;
            oWriteData <= word_buf;
            oEndBit    <= {1'b0, bit_ptr};
          end else begin
            // Final word already written by the packer; pulse done one cycle after it.
            oDone   <= 1'b1;
            oEndBit <= 5'd15;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          oDone <= oWriteEn;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_residual_encoder.sv
// Directed bench for residual_encoder: table of hand-coded blocks with expected RAM
// words and end pointers, plus a mid-residual reset sequence.
module tb_residual_encoder;

  logic        iClock = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iEnable = 1'b0;
  logic [15:0] iNSamples = '0;
  logic [3:0]  iPredOrder = '0;
  logic [3:0]  iPartOrder = '0;
  logic [15:0] iStartAddr = '0;
  logic [4:0]  iStartBit = 5'd15;
  logic [15:0] iStartWord = '0;
  logic        oParamReq;
  logic        iParamValid = 1'b0;
  logic [3:0]  iRiceParam = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [15:0] iResidual = '0;
  logic        oWriteEn;
  logic [15:0] oWriteAddr;
  logic [15:0] oWriteData;
  logic        oDone;
  logic [15:0] oEndAddr;
  logic [4:0]  oEndBit;

  always #5 iClock = ~iClock;

  residual_encoder #(.DATA_W(16)) dut (
    .iClock(iClock), .iReset_n(iReset_n), .iEnable(iEnable), .iNSamples(iNSamples),
    .iPredOrder(iPredOrder), .iPartOrder(iPartOrder), .iStartAddr(iStartAddr),
    .iStartBit(iStartBit), .iStartWord(iStartWord), .oParamReq(oParamReq),
    .iParamValid(iParamValid), .iRiceParam(iRiceParam), .iValid(iValid), .oReady(oReady),
    .iResidual(iResidual), .oWriteEn(oWriteEn), .oWriteAddr(oWriteAddr),
    .oWriteData(oWriteData), .oDone(oDone), .oEndAddr(oEndAddr), .oEndBit(oEndBit)
  );

  typedef struct packed {
    logic [4:0]       sb;
    logic [15:0]      sw;
    logic [15:0]      addr;
    logic [15:0]      n;
    logic [3:0]       p;
    logic [3:0]       o;
    logic [3:0]       k;
    logic             gaps;
    logic [1:0]       nwords;
    logic [1:0][15:0] w;
    logic [15:0]      end_off;
    logic [4:0]       end_bit;
    logic [2:0]       eps;
    logic [3:0]       nres;
    logic [7:0][15:0] res;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [4:0] sb, input logic [15:0] sw, input logic [15:0] addr,
                              input logic [15:0] n, input logic [3:0] p, input logic [3:0] o,
                              input logic [3:0] k, input logic gaps, input logic [1:0] nwords,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] end_off, input logic [4:0] end_bit,
                              input logic [2:0] eps);
    vec_t v;
    v = '0;
    v.sb = sb; v.sw = sw; v.addr = addr; v.n = n; v.p = p; v.o = o; v.k = k;
    v.gaps = gaps; v.nwords = nwords; v.w[0] = w0; v.w[1] = w1;
    v.end_off = end_off; v.end_bit = end_bit; v.eps = eps;
    return v;
  endfunction

  task automatic run_block(input int idx, input vec_t v);
    int          nw = 0, hs = 0, eps = 0, ri = 0, lastw = -100, donec = 0;
    logic [15:0] wa[4];
    logic [15:0] wd[4];
    logic        prev_req = 1'b0;
    logic        fin = 1'b0;
    @(negedge iClock);
    iStartBit = v.sb; iStartWord = v.sw; iStartAddr = v.addr;
    iNSamples = v.n;  iPredOrder = v.p;  iPartOrder = v.o;
    iEnable = 1'b1;
    @(negedge iClock);
    iEnable = 1'b0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      if (oWriteEn) begin
        if (nw < 4) begin wa[nw] = oWriteAddr; wd[nw] = oWriteData; end
        nw++;
        lastw = cyc;
      end
      if (oParamReq && !prev_req) eps++;
      prev_req = oParamReq;
      if (oDone) begin
        donec = cyc;
        fin   = 1'b1;
      end else begin
        // A second start while busy must be ignored.
        iEnable     = (cyc == 8);
        iRiceParam  = v.k;
        iParamValid = oParamReq && (!v.gaps || $urandom_range(0, 2) == 0);
        iValid      = (ri < int'(v.nres)) && (!v.gaps || $urandom_range(0, 2) == 0);
        iResidual   = (ri < 8) ? v.res[ri] : 16'h0;
        if (iValid && oReady) begin hs++; ri++; end
        @(negedge iClock);
      end
    end
    iEnable = 1'b0; iParamValid = 1'b0; iValid = 1'b0;
    check($sformatf("v%0d done_seen", idx), 32'(fin), 32'd1);
    check($sformatf("v%0d nwords", idx), 32'(nw), 32'(v.nwords));
    for (int i = 0; i < int'(v.nwords); i++) begin
      check($sformatf("v%0d waddr%0d", idx, i), 32'(wa[i]), 32'(16'(v.addr + 16'(i))));
      check($sformatf("v%0d wdata%0d", idx, i), 32'(wd[i]), 32'(v.w[i]));
    end
    check($sformatf("v%0d end_addr", idx), 32'(oEndAddr), 32'(16'(v.addr + v.end_off)));
    check($sformatf("v%0d end_bit", idx), 32'(oEndBit), 32'(v.end_bit));
    check($sformatf("v%0d done_lat", idx), 32'(donec - lastw), 32'd1);
    check($sformatf("v%0d handshakes", idx), 32'(hs), 32'(v.nres));
    check($sformatf("v%0d param_eps", idx), 32'(eps), 32'(v.eps));
  endtask

  vec_t vecs[10];

  initial begin
    logic got;
    logic bad;
    vecs[0] = mk(15, 16'h0000, 16'h0000, 2, 0, 0, 2,  0, 2, 16'h009A, 16'h8000, 1, 14, 1);
    vecs[0].nres = 2; vecs[0].res[0] = 16'd3; vecs[0].res[1] = 16'hFFFF;
    vecs[1] = mk(7,  16'hAB55, 16'h0200, 2, 0, 0, 2,  0, 2, 16'hAB00, 16'h9A80, 1, 6, 1);
    vecs[1].nres = 2; vecs[1].res[0] = 16'd3; vecs[1].res[1] = 16'hFFFF;
    vecs[2] = mk(15, 16'h0000, 16'h0300, 1, 0, 0, 14, 0, 2, 16'h0387, 16'hFFF0, 1, 3, 1);
    vecs[2].nres = 1; vecs[2].res[0] = 16'h8000;
    vecs[3] = vecs[2]; vecs[3].k = 4'd15; vecs[3].addr = 16'h0310;
    vecs[4] = mk(15, 16'h0000, 16'h0010, 8, 2, 1, 1,  0, 2, 16'h0464, 16'h3938, 1, 1, 2);
    vecs[4].nres = 6;
    vecs[4].res[0] = 16'd0; vecs[4].res[1] = 16'd1; vecs[4].res[2] = 16'hFFFF;
    vecs[4].res[3] = 16'd2; vecs[4].res[4] = 16'hFFFE; vecs[4].res[5] = 16'd0;
    vecs[5] = mk(15, 16'h0000, 16'h0020, 1, 0, 0, 2,  0, 1, 16'h0085, 16'h0000, 1, 15, 1);
    vecs[5].nres = 1; vecs[5].res[0] = 16'hFFF9;
    vecs[6] = mk(15, 16'h0000, 16'h0030, 2, 3, 0, 5,  0, 1, 16'h0140, 16'h0000, 0, 5, 1);
    vecs[7] = vecs[4]; vecs[7].gaps = 1'b1; vecs[7].addr = 16'h0050;
    vecs[8] = mk(15, 16'h0000, 16'h0060, 4, 1, 2, 0,  0, 2, 16'h0802, 16'h0810, 1, 3, 4);
    vecs[8].nres = 3; vecs[8].res[0] = 16'd0; vecs[8].res[1] = 16'hFFFF; vecs[8].res[2] = 16'd1;
    vecs[9] = vecs[8]; vecs[9].gaps = 1'b1; vecs[9].addr = 16'h0070;

    repeat (3) @(negedge iClock);
    check("rst oParamReq", 32'(oParamReq), 32'd0);
    check("rst oReady", 32'(oReady), 32'd0);
    check("rst oWriteEn", 32'(oWriteEn), 32'd0);
    check("rst oDone", 32'(oDone), 32'd0);
    check("rst oEndAddr", 32'(oEndAddr), 32'd0);
    check("rst oEndBit", 32'(oEndBit), 32'd0);
    iReset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_block(i, vecs[i]);

    // Reset in the middle of a long unary run (residual 100, k=0 -> 200 zeros).
    @(negedge iClock);
    iStartBit = 15; iStartWord = 0; iStartAddr = 16'h0400;
    iNSamples = 1; iPredOrder = 0; iPartOrder = 0; iEnable = 1'b1;
    @(negedge iClock);
    iEnable = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      iParamValid = oParamReq; iRiceParam = 4'd0;
      iValid = 1'b1; iResidual = 16'd100;
      if (oReady) got = 1'b1;
      @(negedge iClock);
    end
    iValid = 1'b0; iParamValid = 1'b0;
    check("rstmid handshake", 32'(got), 32'd1);
    repeat (10) @(negedge iClock);
    #2 iReset_n = 1'b0;
    #1;
    check("rstmid async zero", 32'({oParamReq, oReady, oWriteEn, oDone, oWriteAddr, oWriteData,
                                    oEndAddr, oEndBit} == '0), 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge iClock);
      if (c == 3) iReset_n = 1'b1;
      if (oWriteEn || oDone) bad = 1'b1;
    end
    check("rstmid no activity", 32'(bad), 32'd0);
    run_block(10, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/residual_encoder.md
# residual_encoder

Rice-codes a stream of signed 16-bit FLAC residuals into the partitioned-Rice bitstream format: coding method, partition order, per-partition 4-bit Rice parameter, then zigzag/unary/binary codes. Bits are packed MSB-first into 16-bit words and written to block RAM. It is the write-side counterpart of the residual decoder and sits after the LPC/fixed predictor in the encoder datapath, ahead of the frame writer.

## Interface
Parameters:
- DATA_W, 16, residual width and RAM word width. Only 16 is supported.

Ports:
- iClock  in  1  system clock.
- iReset_n  in  1  asynchronous, active-low reset.
- iEnable  in  1  start pulse; sampled only in S_IDLE.
- iNSamples  in  16  block size N; held stable while busy.
- iPredOrder  in  4  predictor order P.
- iPartOrder  in  4  partition order O.
- iStartAddr  in  16  RAM word address of the first output word.
- iStartBit  in  5  first free bit in that word; 15 or 7 only.
- iStartWord  in  16  current contents of that word; bits above iStartBit are preserved.
- oParamReq  out  1  high while waiting for the partition's Rice parameter.
- iParamValid  in  1  iRiceParam is valid.
- iRiceParam  in  4  Rice parameter k, 0..14. A value of 15 is latched as 14, because no escape coding is done.
- iValid  in  1  iResidual is valid.
- oReady  out  1  the encoder accepts iResidual this cycle.
- iResidual  in  16  signed residual.
- oWriteEn  out  1  one-cycle RAM write strobe.
- oWriteAddr  out  16  RAM write address.
- oWriteData  out  16  RAM write data.
- oDone  out  1  one-cycle pulse when the final word has been written.
- oEndAddr  out  16  address of the next free bit; valid from oDone until the next start.
- oEndBit  out  5  next free bit position; valid from oDone until the next start.

## Operation
- Reset (asynchronous): every output is 0, the state is S_IDLE and the internal counters are cleared.
- Start: iEnable in S_IDLE loads the bit pointer from iStartBit. The word buffer loads iStartWord with the bits at and below iStartBit cleared.
- S_HDR emits 6 bits, MSB-first: coding method 00, then O[3:0].
- Partition size:
  - O=0: N−P.
  - Partition 0 with O>0: (N>>O)−P.
  - Other partitions: N>>O.
  - There are 2^O partitions.
- S_PARAM_WAIT: oParamReq is high. The parameter is latched as k on the cycle iParamValid is high. S_PARAM then emits k as 4 bits.
- S_RES_WAIT: oReady is high. On the cycle iValid && oReady:
  - Compute u = (r<<1) ^ (r>>>15), a 16-bit unsigned value.
  - q = u>>k.
  - rem = u & ((1<<k)−1).
- S_UNARY emits q zeros, S_STOP emits a single 1, and S_REM emits rem MSB-first (skipped when k=0).
- After the last bit of a residual:
  - If the partition is not finished, go to S_RES_WAIT.
  - Else, if more partitions remain, go to S_PARAM_WAIT.
  - Else go to S_FLUSH.
- S_FLUSH: if a partial word is pending, write it with zero padding, then go to S_DONE. S_DONE pulses oDone and returns to S_IDLE.
- Bit pointer decrements once per emitted bit. When it wraps from 0 to 15, the completed word is written and the address increments.

## Timing
- Emission is one bit per cycle in S_HDR, S_PARAM, S_UNARY, S_STOP and S_REM.
- Cost per residual: q+1+k bit cycles plus 1 acceptance cycle.
- oReady is high only in S_RES_WAIT and drops the cycle after acceptance. Gaps in iValid simply stall in S_RES_WAIT.
- oWriteEn is registered and rises the cycle after the 16th bit of a word enters the buffer, with that word's address and data.
- Word completes on the very last bit: that full word is written from the normal path and S_FLUSH writes nothing. oEndAddr is then the next address and oEndBit is 15.
- Otherwise oEndAddr is the flushed address and oEndBit is the next free bit position.
- oDone follows the final oWriteEn by 1 cycle.
- N−P ≤ 0 in partition 0: the partition is empty; its parameter is still requested and emitted, and no residuals are taken.
- iEnable while busy is ignored.
- iReset_n low mid-block aborts immediately, with no flush and no oDone.

## Structure
- Shared package `flac_pkg`:
  - State encodings (S_IDLE, S_HDR, S_PARAM_WAIT, S_PARAM, S_RES_WAIT, S_UNARY, S_STOP, S_REM, S_FLUSH, S_DONE).
  - RICE_PARAM_W=4, PART_ORDER_W=4, CODING_METHOD_RICE=2'b00, RICE_ESCAPE=4'hF.
- Sub-module `rice_encoder`:
  - Does the zigzag mapping and the q/rem split.
  - Serializes one residual into a bit plus bit-valid stream with a done flag.
- The top level owns the partition FSM and the word packer.

## Test plan
- Stimulus: iStartBit=15, N=2, P=0, O=0, k=2, residuals 3 and −1. Response: write 0x009A at iStartAddr, then 0x8000 at +1; oEndAddr=+1, oEndBit=14.
- Stimulus: iStartBit=7, iStartWord=0xAB55, same block as the first test. Response: first word has upper byte 0xAB and lower byte 0x00; the following words carry the same bit sequence shifted by 8.
- Stimulus: N=8, P=2, O=1. Response: exactly 2 oParamReq episodes; 2 residuals taken in partition 0 and 4 in partition 1; total 6 oReady handshakes.
- Stimulus: k=14, residual −32768. Response: u=0xFFFF, q=3; bits 0001 followed by fourteen 1s.
- Stimulus: random iValid/iParamValid gaps, and separately iRiceParam=15. Response: bitstream identical to the no-gap run; a parameter of 15 is emitted as 1110.
- Stimulus: assert iReset_n low during S_UNARY. Response: all outputs 0 asynchronously, no further writes, no oDone; a new iEnable encodes the block correctly.
